// File: rtl/corr_pkg.sv
// Shared types and helpers for the multi-lag correlator.
// Holds the window FSM and scan FSM state encodings and a constant clog2.
// No ports; imported by multi_lag_correlator and corr_peak_scan.
package corr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } win_state_e;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN      = 1'b1
  } scan_state_e;

  // Bits needed to index n items; never less than 1 so a lag index always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/corr_peak_scan.sv
// Sequential argmax over the per-lag snapshot counts, one lag per cycle.
// Latency: valid_o rises LAGS+1 cycles after start_i is sampled; busy_o high for LAGS cycles.
// Backpressure: none; start_i must not arrive while busy_o is high.
// Ports: clk/rst_n clock and async active-low reset; start_i begins a scan;
//   snap_i snapshot counts (stable during scan); result_o scaled peak;
//   peak_lag_o winning lag; valid_o one-cycle result pulse; busy_o scan in progress.
module corr_peak_scan
  import corr_pkg::*;
#(
  parameter int LAGS      = 8,
  parameter int ACC_W     = 11,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_W     = 8,
  parameter int LAG_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [LAGS-1:0][ACC_W-1:0]  snap_i,
  output logic [OUT_W-1:0]            result_o,
  output logic [LAG_W-1:0]            peak_lag_o,
  output logic                        valid_o,
  output logic                        busy_o
);

  scan_state_e        state_q, state_d;
  logic [LAG_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   best_val_q, best_val_d;
  logic [LAG_W-1:0]   best_lag_q, best_lag_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   result_q;
  logic [LAG_W-1:0]   peak_lag_q;
  logic               valid_q;
  logic [ACC_W-1:0]   cur_val;
  logic [ACC_W-1:0]   shifted;
  logic [OUT_W-1:0]   scaled;

  assign cur_val = snap_i[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_val_d = best_val_q;
    best_lag_d = best_lag_q;
    done_d     = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (start_i) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // Lag 0 seeds the running best; afterwards strict '>' keeps the lowest lag on ties.
        if ((idx_q == '0) || (cur_val > best_val_q)) begin
          best_val_d = cur_val;
          best_lag_d = idx_q;
        end
        if (idx_q == LAG_W'(LAGS - 1)) begin
          state_d = SCAN_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + LAG_W'(1);
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  assign shifted = best_val_q >> OUT_SHIFT;

  if (ACC_W > OUT_W) begin : g_sat
    assign scaled = (|shifted[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end else begin : g_nosat
    assign scaled = OUT_W'(shifted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN_IDLE;
      idx_q      <= '0;
      best_val_q <= '0;
      best_lag_q <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      peak_lag_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_val_q <= best_val_d;
      best_lag_q <= best_lag_d;
      done_q     <= done_d;
      valid_q    <= done_q;
      if (done_q) begin
        result_q   <= scaled;
        peak_lag_q <= best_lag_q;
      end
    end
  end

  assign result_o   = result_q;
  assign peak_lag_o = peak_lag_q;
  assign valid_o    = valid_q;
  assign busy_o     = (state_q == SCAN);

endmodule

// File: rtl/multi_lag_correlator.sv
// Correlates a received bit stream against LAGS delayed copies of a reference code over fixed windows.
// Latency: valid pulses LAGS+1 cycles after the edge that closes a WIN-strobe window.
// Backpressure: none; en paces sampling and windows accumulate back to back while scanning.
// Ports: clk/rst_n clock and async active-low reset; run enables accumulation; en sample strobe;
//   sig/code received and reference bits; trigger match threshold; result/peak_lag scaled peak
//   and winning lag; valid new-result pulse; match registered threshold compare; busy scan active.
module multi_lag_correlator
  import corr_pkg::*;
#(
  parameter int LAGS      = 8,
  parameter int WIN_LOG2  = 10,
  parameter int OUT_SHIFT = 4,
  parameter int OUT_W     = 8,
  parameter int MATCH_GE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     en,
  input  logic                     sig,
  input  logic                     code,
  input  logic [OUT_W-1:0]         trigger,
  output logic [OUT_W-1:0]         result,
  output logic [clog2(LAGS)-1:0]   peak_lag,
  output logic                     valid,
  output logic                     match,
  output logic                     busy
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int ACC_W = WIN_LOG2 + 1;
  localparam int LAG_W = clog2(LAGS);

  // A scan must finish before the following window snapshots over its inputs.
  if (WIN < LAGS + 2) begin : g_win_check
    $error("multi_lag_correlator: window of %0d strobes too short for %0d lags", WIN, LAGS);
  end

  win_state_e                  state_q, state_d;
  logic [WIN_LOG2-1:0]         cnt_q, cnt_d;
  logic [LAGS-2:0]             dl_q, dl_d;
  logic [LAGS-1:0][ACC_W-1:0]  acc_q, acc_d, acc_inc;
  logic [LAGS-1:0][ACC_W-1:0]  snap_q, snap_d;
  logic [LAGS-1:0]             tap;
  logic [LAGS-1:0]             hit;
  logic                        start;
  logic                        match_q, match_d;

  // Tap 0 is the live code bit; tap k is the code bit from k strobes ago.
  always_comb begin
    tap    = '0;
    tap[0] = code;
    for (int k = 1; k < LAGS; k++) tap[k] = dl_q[k-1];
  end

  always_comb begin
    hit     = '0;
    acc_inc = acc_q;
    for (int k = 0; k < LAGS; k++) begin
      hit[k]     = ~(sig ^ tap[k]);
      acc_inc[k] = acc_q[k] + {{(ACC_W-1){1'b0}}, hit[k]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    acc_d   = acc_q;
    snap_d  = snap_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          // Partial window is thrown away.
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else if (en) begin
          dl_d[0] = code;
          for (int k = 1; k < LAGS - 1; k++) dl_d[k] = dl_q[k-1];
          if (&cnt_q) begin
            // Last strobe of the window: snapshot includes it, next window starts from zero.
            snap_d = acc_inc;
            acc_d  = '0;
            cnt_d  = '0;
            start  = 1'b1;
          end else begin
            acc_d = acc_inc;
            cnt_d = cnt_q + WIN_LOG2'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dl_q    <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
    end
  end

  corr_peak_scan #(
    .LAGS      (LAGS),
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_W     (OUT_W),
    .LAG_W     (LAG_W)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .snap_i     (snap_q),
    .result_o   (result),
    .peak_lag_o (peak_lag),
    .valid_o    (valid),
    .busy_o     (busy)
  );

  always_comb begin
    match_d = 1'b0;
    if (MATCH_GE != 0) match_d = (result >= trigger);
    else               match_d = (result == trigger);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b0;
    else        match_q <= match_d;
  end

  assign match = match_q;

endmodule
